// File: rtl/sync_dualrail_tx.sv
// sync_dualrail_tx: clocked-to-asynchronous bridge into a dual-rail register stage.
// Binary words arrive on valid/ready, wait in a one-word buffer, and are driven out
// as dual-rail codewords under a four-phase return-to-zero handshake against ack_in.
module sync_dualrail_tx #(
    parameter int N_BITS      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_BITS-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [2*N_BITS-1:0] data_out,
    input  logic                ack_in,
    output logic                busy,
    output logic [7:0]          tx_count,
    output logic                err_timeout
);

    // Fewer than two flops would not be a synchroniser; clamp silently.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam int CNT_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);
    localparam bit TO_EN = (TIMEOUT_CYC != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_HI,
        S_WAIT_LO
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SYNC_N-1:0]     r_ack_sync;
    logic                  w_ack_s;
    logic [N_BITS-1:0]     r_buf;
    logic                  r_buf_full;
    logic                  w_load;
    logic                  w_buf_free;
    logic [2*N_BITS-1:0]   r_data_out;
    logic [2*N_BITS-1:0]   w_data_nxt;
    logic                  w_tx_inc;
    logic [7:0]            r_tx_count;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  r_err;

    // bit=1 -> true rail high (10), bit=0 -> false rail high (01)
    function automatic logic [2*N_BITS-1:0] encode(input logic [N_BITS-1:0] word);
        logic [2*N_BITS-1:0] enc;
        enc = '0;
        for (int unsigned i = 0; i < N_BITS; i++) begin
            enc[2*i+1] = word[i];
            enc[2*i]   = ~word[i];
        end
        return enc;
    endfunction

    assign w_ack_s    = r_ack_sync[SYNC_N-1];
    assign w_load     = in_valid & ~r_buf_full;

    // Synchronise ack_in; flops come out of reset high so a set downstream stage is respected
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_sync <= '1;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_N-2:0], ack_in};
        end
    end

    // One-word holding buffer; load and free are mutually exclusive via in_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= '0;
            r_buf_full <= 1'b0;
        end else if (w_load) begin
            r_buf      <= in_data;
            r_buf_full <= 1'b1;
        end else if (w_buf_free) begin
            r_buf_full <= 1'b0;
        end
    end

    // Handshake next-state, next rail value, buffer free and completion strobe
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data_out;
        w_buf_free  = 1'b0;
        w_tx_inc    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_data_nxt = '0;
                if (r_buf_full && !w_ack_s) begin
                    w_data_nxt  = encode(r_buf);
                    w_buf_free  = 1'b1;
                    w_state_nxt = S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (w_ack_s) begin
                    w_data_nxt  = '0;
                    w_state_nxt = S_WAIT_LO;
                end
            end
            S_WAIT_LO: begin
                if (!w_ack_s) begin
                    w_tx_inc = 1'b1;
                    if (r_buf_full) begin
                        w_data_nxt  = encode(r_buf);
                        w_buf_free  = 1'b1;
                        w_state_nxt = S_WAIT_HI;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_data_nxt  = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Wait-cycle counter: clears in IDLE and on any state change, saturates at the limit
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state == S_IDLE || w_state_nxt != r_state) begin
            w_cnt_nxt = '0;
        end else if (r_cnt != TO_VAL) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    // State, registered rails, completion counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_data_out <= '0;
            r_tx_count <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_out <= w_data_nxt;
            r_cnt      <= w_cnt_nxt;
            if (w_tx_inc) begin
                r_tx_count <= r_tx_count + 8'd1;
            end
            if (TO_EN && w_cnt_nxt == TO_VAL) begin
                r_err <= 1'b1;
            end
        end
    end

    assign in_ready    = ~r_buf_full;
    assign data_out    = r_data_out;
    assign busy        = (r_state != S_IDLE) | r_buf_full;
    assign tx_count    = r_tx_count;
    assign err_timeout = r_err;

endmodule

// File: tb/tb_sync_dualrail_tx.sv
// Testbench for sync_dualrail_tx: directed scenarios plus a randomised downstream
// responder, all checked every cycle against a transaction-level model.
module tb_sync_dualrail_tx;

    localparam int NB  = 4;
    localparam int S   = 2;
    localparam int TO  = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    data_out;
    logic          ack_in;
    logic          busy;
    logic [7:0]    tx_count;
    logic          err_timeout;

    int checks   = 0;
    int failures = 0;

    // model state
    logic [NB-1:0] m_pend[$];
    bit            m_hist[$];
    logic [NB-1:0] m_cur;
    bit            m_fly;
    bit            m_acked;
    int            m_tx;
    int            m_wait;
    bit            m_err;
    int            m_total;

    // responder state
    bit auto_ack = 1'b0;
    int dly      = 0;

    sync_dualrail_tx #(
        .N_BITS(NB),
        .SYNC_STAGES(S),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .data_out(data_out),
        .ack_in(ack_in),
        .busy(busy),
        .tx_count(tx_count),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic int enc(input logic [NB-1:0] w);
        int v = 0;
        for (int i = 0; i < NB; i++) v += (w[i] ? 2 : 1) << (2 * i);
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend.delete();
        m_hist.delete();
        for (int i = 0; i < S; i++) m_hist.push_back(1'b1);
        m_fly   = 1'b0;
        m_acked = 1'b0;
        m_tx    = 0;
        m_wait  = 0;
        m_err   = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs held across that edge
    task automatic model_edge();
        bit ack_s;
        bit accept;
        bit was_fly;
        bit changed;
        if (rst) begin
            model_reset();
            return;
        end
        ack_s = m_hist.pop_front();
        m_hist.push_back(ack_in);
        accept  = in_valid && (m_pend.size() == 0);
        was_fly = m_fly;
        changed = 1'b0;
        if (!m_fly) begin
            if (m_pend.size() != 0 && !ack_s) begin
                m_cur   = m_pend.pop_front();
                m_fly   = 1'b1;
                m_acked = 1'b0;
                changed = 1'b1;
            end
        end else if (!m_acked) begin
            if (ack_s) begin
                m_acked = 1'b1;
                changed = 1'b1;
            end
        end else if (!ack_s) begin
            m_tx++;
            m_total++;
            changed = 1'b1;
            if (m_pend.size() != 0) begin
                m_cur   = m_pend.pop_front();
                m_acked = 1'b0;
            end else begin
                m_fly = 1'b0;
            end
        end
        if (accept) m_pend.push_back(in_data);
        if (!was_fly || changed) m_wait = 0;
        else if (m_wait < TO) m_wait++;
        if (TO != 0 && m_wait == TO) m_err = 1'b1;
    endtask

    task automatic compare();
        int exp_data;
        bit no11 = 1'b1;
        exp_data = (m_fly && !m_acked) ? enc(m_cur) : 0;
        for (int i = 0; i < NB; i++) if (data_out[2*i] && data_out[2*i+1]) no11 = 1'b0;
        chk("data_out", int'(data_out), exp_data);
        chk("in_ready", int'(in_ready), (m_pend.size() == 0) ? 1 : 0);
        chk("busy", int'(busy), (m_fly || m_pend.size() != 0) ? 1 : 0);
        chk("tx_count", int'(tx_count), m_tx % 256);
        chk("err_timeout", int'(err_timeout), int'(m_err));
        chk("no_11_pair", int'(no11), 1);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare();
    endtask

    task automatic respond();
        bit want;
        if (!auto_ack) return;
        want = (data_out != 8'h00);
        if (want != ack_in) begin
            if (dly == 0) begin
                ack_in = want;
                if ($urandom_range(0, 9) == 0) dly = int'($urandom_range(17, 22));
                else dly = int'($urandom_range(0, 4));
            end else begin
                dly--;
            end
        end
    endtask

    task automatic wait_data(input string name, input int exp, input int max);
        int n = 0;
        while (int'(data_out) != exp && n < max) begin
            step();
            n++;
        end
        chk(name, int'(data_out), exp);
    endtask

    task automatic wait_idle(input string name, input int max);
        int n = 0;
        while (busy && n < max) begin
            step();
            n++;
        end
        chk(name, int'(busy), 0);
    endtask

    task automatic send(input logic [NB-1:0] w);
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        model_reset();
        m_total  = 0;
        rst      = 1'b1;
        ack_in   = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h3;

        // T1: reset with ack held high; word waits until ack seen low
        step();
        step();
        chk("t1_reset_data", int'(data_out), 0);
        chk("t1_reset_ready", int'(in_ready), 1);
        rst = 1'b0;
        step();
        chk("t1_accept_ready", int'(in_ready), 0);
        in_valid = 1'b0;
        repeat (5) step();
        chk("t1_held_null", int'(data_out), 0);
        ack_in = 1'b0;
        step();
        step();
        chk("t1_lat2", int'(data_out), 0);
        step();
        chk("t1_lat3", int'(data_out), 8'h5A);
        ack_in = 1'b1;
        wait_data("t1_rtz", 0, 8);
        ack_in = 1'b0;
        wait_idle("t1_idle", 8);
        chk("t1_tx", int'(tx_count), 1);

        // T2: single word after fresh reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(4'b1010);
        wait_data("t2_code", 8'h99, 8);
        ack_in = 1'b1;
        wait_data("t2_rtz", 0, 8);
        ack_in = 1'b0;
        wait_idle("t2_idle", 8);
        chk("t2_tx", int'(tx_count), 1);

        // T3: back-to-back words
        in_valid = 1'b1;
        in_data  = 4'hF;
        step();
        in_data = 4'h0;
        step();
        step();
        in_valid = 1'b0;
        chk("t3_ready_buffered", int'(in_ready), 0);
        chk("t3_first", int'(data_out), 8'hAA);
        ack_in = 1'b1;
        wait_data("t3_rtz1", 0, 8);
        ack_in = 1'b0;
        wait_data("t3_second", 8'h55, 8);
        ack_in = 1'b1;
        wait_data("t3_rtz2", 0, 8);
        ack_in = 1'b0;
        wait_idle("t3_idle", 8);
        chk("t3_tx", int'(tx_count), 3);

        // T4: ack stuck low after codeword
        send(4'h5);
        wait_data("t4_code", 8'h66, 8);
        repeat (TO - 1) step();
        chk("t4_before", int'(err_timeout), 0);
        step();
        chk("t4_err", int'(err_timeout), 1);
        chk("t4_hold", int'(data_out), 8'h66);
        ack_in = 1'b1;
        wait_data("t4_rtz", 0, 8);
        ack_in = 1'b0;
        wait_idle("t4_idle", 8);
        chk("t4_sticky", int'(err_timeout), 1);

        // T5: reset during WAIT_HI with buffer full
        send(4'h7);
        wait_data("t5_code", 8'h6A, 8);
        send(4'h9);
        chk("t5_full_ready", int'(in_ready), 0);
        chk("t5_full_busy", int'(busy), 1);
        rst = 1'b1;
        step();
        chk("t5_data", int'(data_out), 0);
        chk("t5_ready", int'(in_ready), 1);
        chk("t5_tx", int'(tx_count), 0);
        chk("t5_err", int'(err_timeout), 0);
        rst = 1'b0;

        // T6: randomised traffic until 256 handshakes complete
        m_total  = 0;
        auto_ack = 1'b1;
        dly      = 0;
        cyc      = 0;
        while (m_total < 256 && cyc < 40000) begin
            in_valid = ($urandom_range(0, 1) == 1);
            in_data  = NB'($urandom_range(0, 15));
            step();
            respond();
            cyc++;
        end
        chk("t6_handshakes", m_total, 256);
        chk("t6_wrap", int'(tx_count), 0);
        auto_ack = 1'b0;
        in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
